// File: rtl/dsp_ctrl_pkg.sv
// Shared definitions for the DSP48A1 dot-product sequencer.
// Holds the FSM state encoding, the OPMODE field constants, the default
// OPMODE words for the first and accumulating samples, and the pipeline
// stage tag layout used by the stage tracker.
package dsp_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // OPMODE[1:0] = X mux, OPMODE[3:2] = Z mux. Upper bits stay 0: add,
    // pre-adder bypassed, no carry-in.
    localparam logic [1:0] X_M    = 2'b01;
    localparam logic [1:0] Z_ZERO = 2'b00;
    localparam logic [1:0] Z_P    = 2'b10;

    localparam logic [7:0] OPM_FIRST_DEF = {4'b0000, Z_ZERO, X_M};
    localparam logic [7:0] OPM_ACC_DEF   = {4'b0000, Z_P, X_M};

    // Tag travelling alongside each accepted sample through the slice.
    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } tag_t;

endpackage

// File: rtl/dsp_mac_sequencer_stage_tracker.sv
// dsp_stage_tracker
// Two-entry tag shift register that follows each accepted sample through
// the registered DSP48A1 pipeline (M/OPMODE stage, then P stage) and drives
// the matching clock enables. Bubbles carry valid=0, so every enable is low
// and the P register holds its accumulation across stream gaps.
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   accept          sample taken this cycle (A/B registers loading)
//   first, last     sample is first / last of the vector
//   cem, ceopmode   enable M and OPMODE registers (stage t+1)
//   opmode          OPMODE word for the stage t+1 sample, 0 on bubbles
//   cep             enable P register (stage t+2)
//   last_done       one-cycle pulse: last sample's result is on P
module dsp_stage_tracker
    import dsp_ctrl_pkg::*;
#(
    parameter logic [7:0] OPM_FIRST = OPM_FIRST_DEF,
    parameter logic [7:0] OPM_ACC   = OPM_ACC_DEF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       accept,
    input  logic       first,
    input  logic       last,
    output logic       cem,
    output logic       ceopmode,
    output logic [7:0] opmode,
    output logic       cep,
    output logic       last_done
);

    tag_t stage1;
    tag_t stage2;
    logic done_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            stage1 <= '0;
            stage2 <= '0;
            done_q <= 1'b0;
        end else begin
            stage1.valid <= accept;
            stage1.first <= accept & first;
            stage1.last  <= accept & last;
            stage2       <= stage1;
            // P already holds the last product once stage2 has been clocked.
            done_q       <= stage2.valid & stage2.last;
        end
    end

    assign cem       = stage1.valid;
    assign ceopmode  = stage1.valid;
    assign opmode    = !stage1.valid ? 8'h00 :
                       stage1.first  ? OPM_FIRST : OPM_ACC;
    assign cep       = stage2.valid;
    assign last_done = done_q;

endmodule

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer
// Drives one DSP48A1 slice (A1REG/B1REG/MREG/PREG/OPMODEREG = 1) as a
// signed dot-product engine: res_data = sum a[k]*b[k] over len samples,
// wrapping modulo 2^48.
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   start, len, busy         command interface (start sampled in IDLE only)
//   s_valid/s_ready/s_a/s_b  sample stream
//   res_valid/res_ready/res_data  result handshake
//   dsp_a, dsp_b, dsp_opmode, dsp_ce*, dsp_rst  to the slice
//   dsp_p                    from the slice P output
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start
// RUN   | accepting samples, one per cycle, count tracks samples left
// DRAIN | last sample in the slice pipeline, waiting for it to reach P
// DONE  | result presented, held until res_ready
module dsp_mac_sequencer
    import dsp_ctrl_pkg::*;
#(
    parameter int         LEN_W     = 16,
    parameter logic [7:0] OPM_FIRST = OPM_FIRST_DEF,
    parameter logic [7:0] OPM_ACC   = OPM_ACC_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [17:0]      s_a,
    input  logic [17:0]      s_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [47:0]      res_data,
    output logic [17:0]      dsp_a,
    output logic [17:0]      dsp_b,
    output logic [7:0]       dsp_opmode,
    output logic             dsp_cea,
    output logic             dsp_ceb,
    output logic             dsp_cem,
    output logic             dsp_ceopmode,
    output logic             dsp_cep,
    output logic             dsp_rst,
    input  logic [47:0]      dsp_p
);

    state_t           state;
    logic [LEN_W-1:0] count;
    logic             first_pend;
    logic             s_ready_q;
    logic             busy_q;
    logic             res_valid_q;
    logic [47:0]      res_data_q;

    logic             accept;
    logic             is_last;
    logic             last_done;

    // Gated with RST so an aborting cycle never loads the slice input regs.
    assign accept  = s_valid & s_ready_q & ~RST;
    assign is_last = (count == LEN_W'(1));

    assign dsp_a   = s_a;
    assign dsp_b   = s_b;
    assign dsp_cea = accept;
    assign dsp_ceb = accept;
    assign dsp_rst = RST;

    assign s_ready   = s_ready_q;
    assign busy      = busy_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;

    dsp_stage_tracker #(
        .OPM_FIRST (OPM_FIRST),
        .OPM_ACC   (OPM_ACC)
    ) u_tracker (
        .CLK       (CLK),
        .RST       (RST),
        .accept    (accept),
        .first     (first_pend),
        .last      (is_last),
        .cem       (dsp_cem),
        .ceopmode  (dsp_ceopmode),
        .opmode    (dsp_opmode),
        .cep       (dsp_cep),
        .last_done (last_done)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= ST_IDLE;
            count       <= '0;
            first_pend  <= 1'b0;
            s_ready_q   <= 1'b0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if (len != '0) begin
                            state      <= ST_RUN;
                            count      <= len;
                            first_pend <= 1'b1;
                            s_ready_q  <= 1'b1;
                        end else begin
                            // Empty vector: the dot product is 0.
                            state       <= ST_DONE;
                            res_data_q  <= '0;
                            res_valid_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        count      <= count - LEN_W'(1);
                        first_pend <= 1'b0;
                        if (is_last) begin
                            state     <= ST_DRAIN;
                            s_ready_q <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (last_done) begin
                        state       <= ST_DONE;
                        res_data_q  <= dsp_p;
                        res_valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        state       <= ST_IDLE;
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Self-checking bench for dsp_mac_sequencer. Contains a behavioural model
// of the DSP48A1 slice (A1/B1, M, OPMODE and P registers with their clock
// enables) closing the loop on dsp_p. Expected dot products are pushed into
// a scoreboard queue when a vector is issued; a monitor pops and compares
// on every result handshake and checks that a pending result stays stable.
module tb_dsp_mac_sequencer;
    import dsp_ctrl_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic [15:0] len = '0;
    logic        busy;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [17:0] s_a = '0;
    logic [17:0] s_b = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [47:0] res_data;
    logic [17:0] dsp_a;
    logic [17:0] dsp_b;
    logic [7:0]  dsp_opmode;
    logic        dsp_cea, dsp_ceb, dsp_cem, dsp_ceopmode, dsp_cep, dsp_rst;
    logic [47:0] dsp_p;

    always #5 CLK = ~CLK;

    dsp_mac_sequencer #(.LEN_W(16)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .start        (start),
        .len          (len),
        .busy         (busy),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_a          (s_a),
        .s_b          (s_b),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .dsp_a        (dsp_a),
        .dsp_b        (dsp_b),
        .dsp_opmode   (dsp_opmode),
        .dsp_cea      (dsp_cea),
        .dsp_ceb      (dsp_ceb),
        .dsp_cem      (dsp_cem),
        .dsp_ceopmode (dsp_ceopmode),
        .dsp_cep      (dsp_cep),
        .dsp_rst      (dsp_rst),
        .dsp_p        (dsp_p)
    );

    // ---------------- slice model ----------------
    logic signed [17:0] a1, b1;
    logic signed [35:0] m;
    logic [7:0]         opm_r;
    logic [47:0]        p;

    always @(posedge CLK) begin
        if (dsp_rst) begin
            a1 <= '0; b1 <= '0; m <= '0; opm_r <= '0; p <= '0;
        end else begin
            if (dsp_cea) a1 <= dsp_a;
            if (dsp_ceb) b1 <= dsp_b;
            if (dsp_cem) m <= a1 * b1;
            if (dsp_ceopmode) opm_r <= dsp_opmode;
            if (dsp_cep)
                p <= {{12{m[35]}}, m} + ((opm_r[3:2] == Z_P) ? p : 48'd0);
        end
    end
    assign dsp_p = p;

    // ---------------- bookkeeping ----------------
    int cyc = 0;
    int cep_cnt = 0;
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (dsp_cep === 1'b1) cep_cnt <= cep_cnt + 1;
    end

    int checks = 0;
    int failures = 0;
    logic [47:0] exp_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic bound_fail(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: wait bound expired", nm);
    endtask

    // ---------------- monitor ----------------
    logic        hold_prev = 1'b0;
    logic [47:0] prev_data = '0;
    always @(negedge CLK) begin
        if (RST) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("res_valid_held", {63'd0, res_valid}, 64'd1);
                chk("res_data_held", {16'd0, res_data}, {16'd0, prev_data});
            end
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result: got %0d with empty scoreboard", res_data);
                end else begin
                    chk("res_data", {16'd0, res_data}, {16'd0, exp_q.pop_front()});
                end
            end
            hold_prev = res_valid && !res_ready;
            prev_data = res_data;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_start(input logic [15:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    // Returns the cycle number observed just before the accepting edge.
    task automatic send(input logic [17:0] a, input logic [17:0] b, output int acc_cyc);
        s_valid = 1'b1;
        s_a     = a;
        s_b     = b;
        acc_cyc = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (s_ready) begin
                acc_cyc = cyc;
                break;
            end
            tick();
        end
        if (acc_cyc < 0) bound_fail("accept_timeout");
        else tick();
        s_valid = 1'b0;
    endtask

    // The result must appear on the 3rd rising edge after the accepting edge.
    task automatic wait_result(input int acc_cyc, input bit chk_lat);
        bit found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (res_valid) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) bound_fail("result_timeout");
        else if (chk_lat) chk("latency", 64'(cyc - (acc_cyc + 1)), 64'd3);
        tick();
    endtask

    task automatic release_result(input int hold);
        repeat (hold) tick();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int acc;
        int base;

        // Reset state
        RST = 1'b1;
        repeat (2) tick();
        @(negedge CLK);
        chk("rst_busy",      {63'd0, busy},       64'd0);
        chk("rst_res_valid", {63'd0, res_valid},  64'd0);
        chk("rst_res_data",  {16'd0, res_data},   64'd0);
        chk("rst_s_ready",   {63'd0, s_ready},    64'd0);
        chk("rst_cep",       {63'd0, dsp_cep},    64'd0);
        chk("rst_cem",       {63'd0, dsp_cem},    64'd0);
        chk("rst_opmode",    {56'd0, dsp_opmode}, 64'd0);
        chk("rst_dsp_rst",   {63'd0, dsp_rst},    64'd1);
        tick();
        RST = 1'b0;
        tick();

        // 1: back-to-back, 2*3 + 4*5 + (-1)*7 = 19
        exp_q.push_back(48'd19);
        do_start(16'd3);
        chk("t1_busy", {63'd0, busy}, 64'd1);
        send(18'd2, 18'd3, acc);
        send(18'd4, 18'd5, acc);
        send(-18'sd1, 18'd7, acc);
        @(negedge CLK);
        chk("t1_drain_s_ready", {63'd0, s_ready}, 64'd0);
        wait_result(acc, 1'b1);
        release_result(3);

        // 2: gap of 4 cycles, 10*10 + (-3)*6 = 82, P enabled only twice
        exp_q.push_back(48'd82);
        do_start(16'd2);
        base = cep_cnt;
        send(18'd10, 18'd10, acc);
        @(negedge CLK);
        chk("t2_cem_first",    {63'd0, dsp_cem},      64'd1);
        chk("t2_ceopm_first",  {63'd0, dsp_ceopmode}, 64'd1);
        chk("t2_opmode_first", {56'd0, dsp_opmode},   64'h01);
        @(negedge CLK);
        chk("t2_cep_first",    {63'd0, dsp_cep},      64'd1);
        chk("t2_cem_bubble",   {63'd0, dsp_cem},      64'd0);
        tick(); tick(); tick();
        send(-18'sd3, 18'd6, acc);
        @(negedge CLK);
        chk("t2_opmode_acc",   {56'd0, dsp_opmode},   64'h09);
        wait_result(acc, 1'b1);
        release_result(0);
        repeat (3) tick();
        chk("t2_cep_count", 64'(cep_cnt - base), 64'd2);

        // 3: empty vector
        exp_q.push_back(48'd0);
        do_start(16'd0);
        @(negedge CLK);
        chk("t3_res_valid", {63'd0, res_valid}, 64'd1);
        chk("t3_s_ready",   {63'd0, s_ready},   64'd0);
        chk("t3_busy",      {63'd0, busy},      64'd1);
        tick();
        release_result(2);

        // 4: extreme operands
        exp_q.push_back(48'd34359214082);
        do_start(16'd2);
        send(18'h1FFFF, 18'h1FFFF, acc);
        send(18'h1FFFF, 18'h1FFFF, acc);
        wait_result(acc, 1'b1);
        release_result(1);
        exp_q.push_back(48'd17179869184);
        do_start(16'd1);
        send(18'h20000, 18'h20000, acc);
        wait_result(acc, 1'b1);
        release_result(1);

        // 5: reset mid-vector aborts, fresh vector afterwards
        do_start(16'd4);
        send(18'd1, 18'd2, acc);
        send(18'd3, 18'd4, acc);
        RST = 1'b1;
        @(negedge CLK);
        chk("t5_dsp_rst", {63'd0, dsp_rst}, 64'd1);
        tick();
        RST = 1'b0;
        @(negedge CLK);
        chk("t5_busy",      {63'd0, busy},      64'd0);
        chk("t5_res_valid", {63'd0, res_valid}, 64'd0);
        chk("t5_s_ready",   {63'd0, s_ready},   64'd0);
        chk("t5_cep",       {63'd0, dsp_cep},   64'd0);
        repeat (5) tick();
        chk("t5_no_result", {63'd0, res_valid}, 64'd0);
        exp_q.push_back(48'd56);
        do_start(16'd1);
        send(18'd7, 18'd8, acc);
        wait_result(acc, 1'b1);
        release_result(0);

        // 6: long DONE hold, start ignored in DONE and on the handshake cycle
        exp_q.push_back(48'hFFFF_FFFF_FFF4);
        do_start(16'd1);
        send(18'd3, -18'sd4, acc);
        wait_result(acc, 1'b0);
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            len   = 16'd5;
            @(negedge CLK);
            chk("t6_s_ready_hold", {63'd0, s_ready}, 64'd0);
            chk("t6_busy_hold",    {63'd0, busy},    64'd1);
            tick();
        end
        start     = 1'b1;
        res_ready = 1'b1;
        tick();
        start     = 1'b0;
        res_ready = 1'b0;
        @(negedge CLK);
        chk("t6_idle_busy",    {63'd0, busy},    64'd0);
        chk("t6_idle_s_ready", {63'd0, s_ready}, 64'd0);
        tick();
        @(negedge CLK);
        chk("t6_still_idle", {63'd0, busy}, 64'd0);
        tick();

        // Scoreboard must be drained
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dsp_mac_sequencer.md
Name: dsp_mac_sequencer

Overview:
- Sequences one DSP48A1 slice as a signed dot-product engine: result = sum of a[k]*b[k] over LEN sample pairs.
- Accepts a start command with a length, then a valid/ready sample stream.
- Drives the slice's A, B, OPMODE, clock-enable and reset pins, and returns the 48-bit accumulation on a valid/ready result port.
- Sits between the stream front-end and a slice built with A0REG=0, A1REG=1, B0REG=0, B1REG=1, MREG=1, PREG=1, OPMODEREG=1, B_INPUT="DIRECT".

Parameters:
- LEN_W, 16, width of the length field; maximum vector length 2^LEN_W-1.
- OPM_FIRST, 8'b00000001, OPMODE for the first sample: X=M, Z=0, add, pre-adder bypassed, no carry-in.
- OPM_ACC, 8'b00001001, OPMODE for later samples: X=M, Z=P, add.

Ports:
- CLK  in  1  clock; all logic on its rising edge.
- RST  in  1  synchronous reset, active-high.
- start  in  1  command strobe; sampled only in IDLE.
- len  in  LEN_W  vector length; captured with start.
- busy  out  1  high in every state except IDLE.
- s_valid  in  1  sample valid.
- s_ready  out  1  sample ready; high only in RUN.
- s_a  in  18  signed sample a.
- s_b  in  18  signed sample b.
- res_valid  out  1  result valid.
- res_ready  in  1  result ready.
- res_data  out  48  accumulated result, two's complement.
- dsp_a  out  18  to slice A.
- dsp_b  out  18  to slice B.
- dsp_opmode  out  8  to slice OPMODE.
- dsp_cea, dsp_ceb  out  1  to slice CEA/CEB.
- dsp_cem  out  1  to slice CEM.
- dsp_ceopmode  out  1  to slice CEOPMODE.
- dsp_cep  out  1  to slice CEP.
- dsp_rst  out  1  to all slice RST* pins.
- dsp_p  in  48  from slice P.

Behaviour:
- Reset (RST=1 at an edge): state=IDLE, remaining count=0, res_valid=0, res_data=0, busy=0, stage tags cleared, all dsp_ce*=0, dsp_opmode=0.
- dsp_rst = RST combinationally. Reset mid-operation aborts the vector; no result is produced.
- dsp_a/dsp_b = s_a/s_b combinationally. Slice CEC, CED and CECARRYIN are tied 0 outside this block.
- Accept: a sample is taken in a cycle where s_valid & s_ready.
- Pipeline timing, sample accepted in cycle t:
  - cycle t: dsp_cea=dsp_ceb=1.
  - cycle t+1: dsp_cem=1, dsp_ceopmode=1, dsp_opmode = OPM_FIRST if the sample is first of the vector, else OPM_ACC.
  - cycle t+2: dsp_cep=1.
  - dsp_p reflects the sample at t+3.
- Implementation: 2-entry tag shift register {valid, first, last}. All CEs are low on bubbles, so the P feedback holds across gaps.
- State machine:
  - IDLE: start & len!=0 -> RUN, load count=len. start & len==0 -> DONE with res_data=0.
  - RUN: s_ready=1. Each accept decrements count. The accept with count==1 is tagged last -> DRAIN.
  - DRAIN: wait until the last-tagged sample has left stage t+2, i.e. one cycle after its dsp_cep. In that cycle capture res_data<=dsp_p and set res_valid=1 -> DONE.
  - DONE: hold res_valid/res_data stable until res_ready. The handshake cycle clears res_valid -> IDLE.
- start outside IDLE is ignored. A new start is not accepted in the DONE->IDLE transition cycle.
- Arithmetic: 18x18 signed product sign-extended to 48 bits. Accumulation wraps modulo 2^48 with no saturation and no flag.
- Throughput: one sample per cycle in RUN. Result valid 3 cycles after the last accept.

Decomposition:
- Shared package dsp_ctrl_pkg holds:
  - state encoding: IDLE, RUN, DRAIN, DONE;
  - OPMODE field constants: X_M=2'b01, Z_ZERO=2'b00, Z_P=2'b10;
  - default OPM_FIRST/OPM_ACC.
- One natural sub-module, dsp_stage_tracker: the 2-stage tag shift register generating dsp_cem, dsp_ceopmode, dsp_cep, opmode select and the last-done pulse.

Test Plan:
- len=3; samples (2,3),(4,5),(-1,7), back-to-back -> res_data=19 exactly 3 cycles after the last accept; res_valid held until res_ready.
- len=2; samples (10,10), 4-cycle gap, (-3,6) -> dsp_cep pulses only twice; res_data=82.
- len=0 start -> DONE with no s_ready; res_data=0, res_valid=1.
- len=2; samples (0x1FFFF,0x1FFFF) twice -> res_data=2*(131071^2)=34359214082 (0x7FFF80002); repeat with len=1, (-131072,-131072) -> 17179869184.
- RST asserted one cycle after the 2nd of 4 samples -> busy=0, res_valid=0, dsp_rst=1 that cycle; a fresh len=1, (7,8) vector then yields 56.
- Hold res_ready=0 for 5 cycles in DONE and pulse start -> res_data stable, start ignored, s_ready=0.
